// File: rtl/mips_int_ctrl.sv
// External-interrupt controller: per-channel mask/edge-mode, sticky pending, fixed-priority arbitration
// and a request/service handshake to the core. Define MIPS_INT_SYNC_EN to add 2-flop input synchronisers.
module mips_int_ctrl #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned IDW   = $clog2(N_IRQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_glob_en,
  input  logic             i_int_ack,
  input  logic             i_eret,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [N_IRQ-1:0] i_cfg_wdata,
  output logic [N_IRQ-1:0] o_cfg_rdata,
  output logic             o_int_req,
  output logic [IDW-1:0]   o_int_id,
  output logic             o_in_service
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] hist_q;
  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] eligible;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   winner;

`ifdef MIPS_INT_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = i_irq;
`endif

  // Configuration register writes; PEND writes are write-1-to-clear
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    w1c    = '0;
    if (i_cfg_we) begin
      case (i_cfg_addr)
        2'd0:    mask_d = i_cfg_wdata;
        2'd1:    edge_d = i_cfg_wdata;
        2'd2:    w1c    = i_cfg_wdata;
        default: ;
      endcase
    end
  end

  // Edge channels: set beats clear. Level channels: follow the synchronised input.
  assign rise     = irq_s & ~hist_q;
  assign ack_clr  = (state_q == ST_REQ && i_int_ack) ? (N_IRQ'(1) << id_q) : '0;
  assign pend_d   = (edge_q & (rise | (pend_q & ~(ack_clr | w1c)))) | (~edge_q & irq_s);
  assign eligible = pend_q & mask_q;

  // Lowest set index wins
  always_comb begin
    winner = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      mask_q  <= '0;
      edge_q  <= '1;
      pend_q  <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      hist_q  <= irq_s;
    end
  end

  // Request withdraws if the latched channel loses eligibility before acknowledge
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (i_glob_en && (|eligible)) begin
          state_d = ST_REQ;
          id_d    = winner;
        end
      end
      ST_REQ: begin
        if (i_int_ack)           state_d = ST_SERVICE;
        else if (!eligible[id_q]) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (i_eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_int_req    = 1'b0;
    o_in_service = 1'b0;
    case (state_q)
      ST_REQ:     o_int_req    = 1'b1;
      ST_SERVICE: o_in_service = 1'b1;
      default: ;
    endcase
  end

  assign o_int_id = id_q;

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      2'd0:    o_cfg_rdata = mask_q;
      2'd1:    o_cfg_rdata = edge_q;
      2'd2:    o_cfg_rdata = pend_q;
      default: o_cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Self-checking bench for mips_int_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_mips_int_ctrl;

`ifdef MIPS_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] irq;
  logic       glob_en;
  logic       int_ack;
  logic       eret;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       int_req;
  logic [2:0] int_id;
  logic       in_service;

  int n_tests = 0;
  int n_fail  = 0;

  mips_int_ctrl #(.N_IRQ(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq       (irq),
    .i_glob_en   (glob_en),
    .i_int_ack   (int_ack),
    .i_eret      (eret),
    .i_cfg_we    (cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_wdata (cfg_wdata),
    .o_cfg_rdata (cfg_rdata),
    .o_int_req   (int_req),
    .o_int_id    (int_id),
    .o_in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 2'd2; cfg_wdata = 8'h00;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq = 8'h00; glob_en = 1'b0; int_ack = 1'b0; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd2; cfg_wdata = 8'h00;
    #12;
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", int_req); end
    n_tests++; if (int_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d exp 0", int_id); end
    n_tests++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_svc: got %b exp 0", in_service); end
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h exp 00", cfg_rdata); end
    cfg_addr = 2'd0; #1;
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h exp 00", cfg_rdata); end
    cfg_addr = 2'd1; #1;
    n_tests++; if (cfg_rdata !== 8'hFF) begin n_fail++; $display("FAIL reset_edge: got %h exp ff", cfg_rdata); end
    cfg_addr = 2'd3; #1;
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsvd: got %h exp 00", cfg_rdata); end
    cfg_addr = 2'd2;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    cfg_write(2'd0, 8'hFF);
    glob_en = 1'b1;
    irq = 8'h08;
    repeat (LAT + 1) tick();
    n_tests++; if (cfg_rdata !== 8'h08) begin n_fail++; $display("FAIL single_pend: got %h exp 08", cfg_rdata); end
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b exp 0", int_req); end
    irq = 8'h00;
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd3) begin n_fail++; $display("FAIL single_req: got req=%b id=%0d exp req=1 id=3", int_req, int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b1) begin n_fail++; $display("FAIL single_ack: got req=%b svc=%b exp req=0 svc=1", int_req, in_service); end
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL single_ack_pend: got %h exp 00", cfg_rdata); end
    eret = 1'b1; tick(); eret = 1'b0;
    n_tests++; if (in_service !== 1'b0 || int_req !== 1'b0) begin n_fail++; $display("FAIL single_eret: got req=%b svc=%b exp 0/0", int_req, in_service); end
  endtask

  task automatic test_priority();
    irq = 8'h24;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd2) begin n_fail++; $display("FAIL prio_first: got req=%b id=%0d exp req=1 id=2", int_req, int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    n_tests++; if (cfg_rdata !== 8'h20 || int_id !== 3'd2) begin n_fail++; $display("FAIL prio_ack: got pend=%h id=%0d exp pend=20 id=2", cfg_rdata, int_id); end
    eret = 1'b1; tick(); eret = 1'b0;
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL prio_eret: got req=%b svc=%b exp 0/0", int_req, in_service); end
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd5) begin n_fail++; $display("FAIL prio_second: got req=%b id=%0d exp req=1 id=5", int_req, int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0; #1;
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL prio_pend_end: got %h exp 00", cfg_rdata); end
  endtask

  task automatic test_level_withdraw();
    cfg_write(2'd1, 8'hFE);
    irq = 8'h01;
    repeat (LAT + 1) tick();
    n_tests++; if (cfg_rdata !== 8'h01) begin n_fail++; $display("FAIL level_pend: got %h exp 01", cfg_rdata); end
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd0) begin n_fail++; $display("FAIL level_req: got req=%b id=%0d exp req=1 id=0", int_req, int_id); end
    irq = 8'h00;
    repeat (LAT + 1) tick();
    n_tests++; if (cfg_rdata !== 8'h00 || int_req !== 1'b1) begin n_fail++; $display("FAIL level_drop: got pend=%h req=%b exp pend=00 req=1", cfg_rdata, int_req); end
    tick();
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL level_withdraw: got req=%b svc=%b exp 0/0", int_req, in_service); end
    cfg_write(2'd1, 8'hFF);
  endtask

  task automatic test_w1c_mask();
    irq = 8'h10;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd4) begin n_fail++; $display("FAIL w1c_req: got req=%b id=%0d exp req=1 id=4", int_req, int_id); end
    cfg_write(2'd2, 8'h10);
    n_tests++; if (cfg_rdata !== 8'h00 || int_req !== 1'b1) begin n_fail++; $display("FAIL w1c_write: got pend=%h req=%b exp pend=00 req=1", cfg_rdata, int_req); end
    tick();
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL w1c_withdraw: got req=%b svc=%b exp 0/0", int_req, in_service); end
    cfg_write(2'd0, 8'h00);
    irq = 8'h02;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    n_tests++; if (cfg_rdata !== 8'h02) begin n_fail++; $display("FAIL masked_pend: got %h exp 02", cfg_rdata); end
    tick(); tick();
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL masked_noreq: got %b exp 0", int_req); end
    cfg_write(2'd2, 8'h02);
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL masked_clear: got %h exp 00", cfg_rdata); end
    cfg_write(2'd0, 8'hFF);
  endtask

  task automatic test_service_block();
    irq = 8'h40;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq = 8'h01;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    n_tests++; if (cfg_rdata !== 8'h01) begin n_fail++; $display("FAIL svc_pend: got %h exp 01", cfg_rdata); end
    tick(); tick();
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b1 || int_id !== 3'd6) begin n_fail++; $display("FAIL svc_hold: got req=%b svc=%b id=%0d exp 0/1/6", int_req, in_service, int_id); end
    eret = 1'b1; tick(); eret = 1'b0;
    n_tests++; if (int_req !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL svc_eret: got req=%b svc=%b exp 0/0", int_req, in_service); end
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd0) begin n_fail++; $display("FAIL svc_next: got req=%b id=%0d exp req=1 id=0", int_req, int_id); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_latency_glob();
    glob_en = 1'b0;
    irq = 8'h04;
    for (int c = 0; c <= LAT; c++) begin
      tick();
      n_tests++;
      if (cfg_rdata !== ((c == LAT) ? 8'h04 : 8'h00)) begin
        n_fail++; $display("FAIL latency_edge%0d: got %h exp %h", c, cfg_rdata, (c == LAT) ? 8'h04 : 8'h00);
      end
    end
    irq = 8'h00;
    tick(); tick();
    n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL glob_off: got %b exp 0", int_req); end
    glob_en = 1'b1; tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd2) begin n_fail++; $display("FAIL glob_on: got req=%b id=%0d exp req=1 id=2", int_req, int_id); end
    glob_en = 1'b0; tick();
    n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL glob_drop_keep: got %b exp 1", int_req); end
    int_ack = 1'b1; tick(); int_ack = 1'b0; #1;
    n_tests++; if (in_service !== 1'b1 || cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL glob_ack: got svc=%b pend=%h exp 1/00", in_service, cfg_rdata); end
    eret = 1'b1; tick(); eret = 1'b0;
    glob_en = 1'b1;
  endtask

  task automatic test_async_reset();
    irq = 8'h80;
    repeat (LAT + 1) tick();
    irq = 8'h00;
    tick();
    n_tests++; if (int_req !== 1'b1 || int_id !== 3'd7) begin n_fail++; $display("FAIL arst_pre: got req=%b id=%0d exp req=1 id=7", int_req, int_id); end
    #2; rst_n = 1'b0; #1;
    n_tests++; if (int_req !== 1'b0 || int_id !== 3'd0 || in_service !== 1'b0) begin n_fail++; $display("FAIL arst_out: got req=%b id=%0d svc=%b exp 0/0/0", int_req, int_id, in_service); end
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_pend: got %h exp 00", cfg_rdata); end
    cfg_addr = 2'd0; #1;
    n_tests++; if (cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_mask: got %h exp 00", cfg_rdata); end
    cfg_addr = 2'd2; #1;
    rst_n = 1'b1;
    cfg_write(2'd0, 8'hFF);
    tick(); tick();
    n_tests++; if (int_req !== 1'b0 || cfg_rdata !== 8'h00) begin n_fail++; $display("FAIL arst_discard: got req=%b pend=%h exp 0/00", int_req, cfg_rdata); end
  endtask

  // Reference model: pending rules, eligibility and the request handshake evaluated per clock edge
  task automatic test_random();
    logic [7:0] m_pend, m_mask, m_edg, m_prev, eff, elig, clr, np;
    logic [7:0] dq[$];
    int m_st, m_id;
    rst_n = 1'b0; irq = 8'h00; glob_en = 1'b1; int_ack = 1'b0; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd2; cfg_wdata = 8'h00;
    #2; rst_n = 1'b1; #1;
    m_pend = 8'h00; m_mask = 8'h00; m_edg = 8'hFF; m_prev = 8'h00; m_st = 0; m_id = 0;
    dq = {};
    repeat (LAT) dq.push_back(8'h00);
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      glob_en   = ($urandom_range(0, 9) != 0);
      int_ack   = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 3) == 0);
      cfg_we    = ($urandom_range(0, 11) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 8'($urandom);
      if (cfg_we && cfg_addr == 2'd0 && $urandom_range(0, 1) == 1) cfg_wdata = 8'hFF;
      if (LAT == 0) eff = irq;
      else begin eff = dq.pop_front(); dq.push_back(irq); end
      elig = m_pend & m_mask;
      clr = 8'h00;
      if (m_st == 1 && int_ack) clr[m_id] = 1'b1;
      if (cfg_we && cfg_addr == 2'd2) clr = clr | cfg_wdata;
      for (int b = 0; b < 8; b++) begin
        if (m_edg[b]) np[b] = (eff[b] && !m_prev[b]) || (m_pend[b] && !clr[b]);
        else          np[b] = eff[b];
      end
      case (m_st)
        0: if (glob_en && elig != 8'h00) begin
             m_st = 1;
             for (int b = 0; b < 8; b++) if (elig[b]) begin m_id = b; break; end
           end
        1: if (int_ack) m_st = 2; else if (!elig[m_id]) m_st = 0;
        default: if (eret) m_st = 0;
      endcase
      m_pend = np;
      m_prev = eff;
      if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
      if (cfg_we && cfg_addr == 2'd1) m_edg  = cfg_wdata;
      tick();
      cfg_we = 1'b0; cfg_addr = 2'd2; int_ack = 1'b0; eret = 1'b0;
      #1;
      n_tests++;
      if (int_req !== (m_st == 1) || in_service !== (m_st == 2) || int_id !== 3'(m_id)) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: got req=%b svc=%b id=%0d exp req=%b svc=%b id=%0d",
                 c, int_req, in_service, int_id, (m_st == 1), (m_st == 2), m_id);
      end
      n_tests++;
      if (cfg_rdata !== m_pend) begin
        n_fail++; $display("FAIL rand_pend cyc %0d: got %h exp %h", c, cfg_rdata, m_pend);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_level_withdraw();
    test_w1c_mask();
    test_service_block();
    test_latency_glob();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_int_ctrl.md
# mips_int_ctrl

Parametrised external-interrupt controller for the MIPS core. It accepts `N_IRQ` asynchronous request lines and gives each one its own mask bit and edge/level mode. It latches pending requests, picks the highest-priority channel (lowest index), and presents a single request plus channel ID to the core. A three-state handshake then tracks acknowledge and ERET. It replaces the core's single raw `i_ext_int` input and sits between the top-level interrupt pins and the core's exception logic.

## Interface
Parameters:
- `N_IRQ`, 8, number of interrupt channels; legal range 2..32.
- `IDW`, `$clog2(N_IRQ)`, width of the channel ID; derived, never overridden.

Ports:
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_irq` input N_IRQ: raw external request lines, asynchronous to `i_clk`.
- `i_glob_en` input 1: global interrupt enable from the core status register.
- `i_int_ack` input 1: one-cycle pulse; the core has taken the interrupt.
- `i_eret` input 1: one-cycle pulse; the core has returned from the handler.
- `i_cfg_we` input 1: configuration write strobe.
- `i_cfg_addr` input 2: register select; 0=MASK, 1=EDGE, 2=PEND (write-1-to-clear), 3=reserved.
- `i_cfg_wdata` input N_IRQ: configuration write data.
- `o_cfg_rdata` output N_IRQ: combinational read of the register at `i_cfg_addr`; 0 for addr 3.
- `o_int_req` output 1: interrupt request to the core.
- `o_int_id` output IDW: ID of the requesting channel, or of the channel in service.
- `o_in_service` output 1: high while a handler is running.

## Operation
- Reset values:
  - MASK = 0, so every channel is disabled.
  - EDGE = all ones, so every channel is edge mode.
  - PEND = 0; the state machine is in IDLE.
  - `o_int_req` = 0, `o_int_id` = 0, `o_in_service` = 0.
  - Synchroniser and edge-history flops = 0.
- MASK bit 1 enables the channel. EDGE bit 1 selects rising-edge mode; 0 selects level mode.
- Edge-mode channels:
  - A synchronised 0->1 transition sets the PEND bit. The bit is sticky.
  - The bit clears on `i_int_ack` for that channel, or on a PEND write with a 1 in that position.
  - If a set and a clear land in the same cycle, the set wins.
- Level-mode channels: the PEND bit copies the synchronised level every cycle. Acknowledge and W1C have no effect on them.
- Masked channels still update PEND; they are only excluded from arbitration.
- Arbitration: `eligible = PEND & MASK`. The winner is the lowest set index.
- State machine:
  - IDLE: if `i_glob_en` and eligible is non-zero, latch the winner into `o_int_id` and go to REQ.
  - REQ: `o_int_req` = 1 and `o_int_id` is frozen.
    - On `i_int_ack`, go to SERVICE.
    - Otherwise, if the latched channel's eligible bit drops (level released, masked, or W1C), withdraw: `o_int_req` falls and the state returns to IDLE.
    - `i_glob_en` dropping does not withdraw the request.
  - SERVICE: `o_in_service` = 1, `o_int_req` = 0, `o_int_id` is held. No new request is raised. On `i_eret`, go to IDLE.
- `i_int_ack` outside REQ and `i_eret` outside SERVICE are ignored.
- Reset asserted in any state returns everything to its reset values immediately; pending edges are discarded.

## Timing
- Input-to-PEND latency: an `i_irq` rising edge that meets setup before clock edge k sets PEND at edge k+2 with the synchroniser, or at edge k without it.
- PEND-to-request latency: PEND set at edge n raises `o_int_req` at edge n+1 when eligible and `i_glob_en` = 1.
- Acknowledge at edge m:
  - `o_int_req` is 0 and `o_in_service` is 1 after edge m.
  - The edge-mode PEND bit clears at edge m.
- ERET at edge m: IDLE after edge m. A new request can appear at edge m+1.
- Configuration writes take effect at the write edge. Arbitration in the same cycle uses the pre-write values.
- Input pulses must be at least 2 `i_clk` periods wide with the synchroniser, or 1 period without it. Shorter pulses may be lost.

## Configuration
- `MIPS_INT_SYNC_EN` defined: every `i_irq` bit passes through a 2-flop synchroniser, and edge history is taken after it. Latency is as given under Timing.
- `MIPS_INT_SYNC_EN` undefined: `i_irq` is sampled directly by the edge-history flop. Latency is 2 cycles shorter. Use this only when the inputs are already synchronous to `i_clk`.

## Test plan
- Reset, then write MASK=0xFF. Pulse `i_irq[3]` for 1 cycle (no-sync build) with `i_glob_en`=1. Expect PEND=0x08, then `o_int_req`=1 with `o_int_id`=3 one cycle later. Ack: PEND=0x00, `o_in_service`=1. ERET: back to IDLE.
- Raise `i_irq[5]` and `i_irq[2]` in the same cycle, MASK=0xFF. Expect ID=2 first. After ack and ERET, expect ID=5.
- Level channel: EDGE=0xFE, hold `i_irq[0]`=1. Expect a request with ID=0. Drop `i_irq[0]` before ack. Expect `o_int_req` to fall and the state to return to IDLE with no service.
- In REQ on channel 4, write PEND=0x10. Expect withdrawal. Also write MASK=0x00 with `i_irq[1]` pulsed: PEND bit 1 is set but there is no request.
- In SERVICE, pulse `i_irq[0]`. Expect no request until ERET, then ID=0 on the next cycle.
- Assert `i_rst_n`=0 during REQ. Expect all outputs 0 and PEND=0 asynchronously. With `MIPS_INT_SYNC_EN`, verify the 3-edge input-to-PEND latency.
